// File: rtl/contador_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : contador_monitor_if                                          |
// | Description : Sample/clear inputs and status outputs of contador_monitor.   |
// |               The master side drives the counter bus, enable and clear;    |
// |               the slave side is the monitor itself.                        |
// |               Optional macro SEQMON_HIST_EN adds the 16-bit code histogram.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface contador_monitor_if #(
    parameter int PW = 8
);
    logic          e;
    logic [3:0]    d;
    logic          clr;
    logic          lock;
    logic [PW-1:0] period;
    logic [7:0]    wraps;
    logic          err_illegal;
    logic          err_period;
    logic          err_stuck;
`ifdef SEQMON_HIST_EN
    logic [15:0]   hist;
`endif

    modport master (
        output e, d, clr,
`ifdef SEQMON_HIST_EN
        input  hist,
`endif
        input  lock, period, wraps, err_illegal, err_period, err_stuck
    );

    modport slave (
        input  e, d, clr,
`ifdef SEQMON_HIST_EN
        output hist,
`endif
        output lock, period, wraps, err_illegal, err_period, err_stuck
    );
endinterface
`default_nettype wire

// File: rtl/contador_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : contador_monitor                                             |
// | Description : Checker for a 4-bit counter bus. Measures the period between |
// |               consecutive START_CODE samples, declares lock after two      |
// |               consecutive correct periods, and raises sticky errors for    |
// |               illegal codes, wrong period / counter overflow and a stuck   |
// |               bus. Optional macro SEQMON_HIST_EN adds a code histogram.    |
// |               The PW of the connected interface must equal PW here.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module contador_monitor #(
    parameter logic [3:0]  START_CODE      = 4'd9,
    parameter int          EXPECTED_PERIOD = 8,
    parameter logic [15:0] LEGAL_MASK      = 16'hFFFF,
    parameter int          STUCK_LIMIT     = 4,
    parameter int          PW              = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    contador_monitor_if.slave mon
);

    localparam int RW = $clog2(STUCK_LIMIT + 1);

    // Counter value at which one more non-start sample reaches 2^PW-1.
    localparam logic [PW-1:0] c_cnt_ovf  = {{(PW-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0] c_cnt_one  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] c_expected = PW'(EXPECTED_PERIOD);
    localparam logic [RW-1:0] c_stuck    = RW'(STUCK_LIMIT);
    localparam logic [RW-1:0] c_run_one  = RW'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_cnt;
    logic [1:0]    r_good;
    logic [3:0]    r_prev;
    logic [RW-1:0] r_run;
    logic          r_lock;
    logic [PW-1:0] r_period;
    logic [7:0]    r_wraps;
    logic          r_err_illegal;
    logic          r_err_period;
    logic          r_err_stuck;

    logic [PW-1:0] w_cnt_nxt;
    logic [1:0]    w_good_nxt;
    logic          w_lock_nxt;
    logic [PW-1:0] w_period_nxt;
    logic          w_set_period;
    logic [RW-1:0] w_run_nxt;
    logic          w_set_stuck;
    logic          w_set_illegal;
    logic          w_hit;
    logic          w_cnt_ovf;

    assign w_hit         = (mon.d == START_CODE);
    assign w_cnt_ovf     = (r_cnt == c_cnt_ovf);
    assign w_set_illegal = ~LEGAL_MASK[mon.d];
    assign w_set_stuck   = (w_run_nxt == c_stuck);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, period counter, lock qualification and period-error request.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_good_nxt   = r_good;
        w_lock_nxt   = r_lock;
        w_period_nxt = r_period;
        w_set_period = 1'b0;
        if (mon.e) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_hit) begin
                        w_state_nxt = ST_MEASURE;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                ST_MEASURE: begin
                    if (w_hit) begin
                        w_period_nxt = r_cnt;
                        w_cnt_nxt    = c_cnt_one;
                        if (r_cnt == c_expected) begin
                            w_good_nxt = r_good + 2'd1;
                            if (r_good == 2'd1) begin
                                w_state_nxt = ST_LOCKED;
                                w_lock_nxt  = 1'b1;
                            end
                        end else begin
                            w_set_period = 1'b1;
                            w_good_nxt   = 2'd0;
                        end
                    end else if (w_cnt_ovf) begin
                        w_set_period = 1'b1;
                        w_lock_nxt   = 1'b0;
                        w_good_nxt   = 2'd0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_SEARCH;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit) begin
                        w_period_nxt = r_cnt;
                        w_cnt_nxt    = c_cnt_one;
                        if (r_cnt != c_expected) begin
                            w_set_period = 1'b1;
                            w_lock_nxt   = 1'b0;
                            w_good_nxt   = 2'd0;
                            w_state_nxt  = ST_MEASURE;
                        end
                    end else if (w_cnt_ovf) begin
                        w_set_period = 1'b1;
                        w_lock_nxt   = 1'b0;
                        w_good_nxt   = 2'd0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_SEARCH;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    // Run length of identical samples; a change restarts the run at 1.
    always_comb begin
        w_run_nxt = c_run_one;
        if (mon.d == r_prev) begin
            w_run_nxt = (r_run == c_stuck) ? r_run : r_run + c_run_one;
        end
    end

    // Datapath registers; frozen while the enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_good   <= 2'd0;
            r_prev   <= 4'd0;
            r_run    <= '0;
            r_lock   <= 1'b0;
            r_period <= '0;
            r_wraps  <= 8'd0;
        end else if (mon.e) begin
            r_cnt    <= w_cnt_nxt;
            r_good   <= w_good_nxt;
            r_prev   <= mon.d;
            r_run    <= w_run_nxt;
            r_lock   <= w_lock_nxt;
            r_period <= w_period_nxt;
            if (w_hit && (r_wraps != 8'hFF)) begin
                r_wraps <= r_wraps + 8'd1;
            end
        end
    end

    // Sticky error flags; clear acts without enable and beats a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_illegal <= 1'b0;
            r_err_period  <= 1'b0;
            r_err_stuck   <= 1'b0;
        end else if (mon.clr) begin
            r_err_illegal <= 1'b0;
            r_err_period  <= 1'b0;
            r_err_stuck   <= 1'b0;
        end else if (mon.e) begin
            if (w_set_illegal) r_err_illegal <= 1'b1;
            if (w_set_period)  r_err_period  <= 1'b1;
            if (w_set_stuck)   r_err_stuck   <= 1'b1;
        end
    end

`ifdef SEQMON_HIST_EN
    logic [15:0] r_hist;

    // Histogram of every code seen on an enabled sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 16'd0;
        end else if (mon.clr) begin
            r_hist <= 16'd0;
        end else if (mon.e) begin
            r_hist[mon.d] <= 1'b1;
        end
    end

    assign mon.hist = r_hist;
`endif

    assign mon.lock        = r_lock;
    assign mon.period      = r_period;
    assign mon.wraps       = r_wraps;
    assign mon.err_illegal = r_err_illegal;
    assign mon.err_period  = r_err_period;
    assign mon.err_stuck   = r_err_stuck;

endmodule
`default_nettype wire

// File: tb/tb_contador_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_contador_monitor                                          |
// | Description : Scoreboard bench for contador_monitor. Two instances share   |
// |               one stimulus stream: A (PW=8, code 15 illegal) and B (PW=4). |
// |               Honours SEQMON_HIST_EN when defined.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_contador_monitor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    contador_monitor_if #(.PW(8)) if_a ();
    contador_monitor_if #(.PW(4)) if_b ();

    contador_monitor #(.LEGAL_MASK(16'h7FFF), .PW(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .mon (if_a)
    );

    contador_monitor #(.PW(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .mon (if_b)
    );

    typedef struct {
        logic        lock;
        logic [7:0]  period;
        logic [7:0]  wraps;
        logic        ei;
        logic        ep;
        logic        es;
        logic [15:0] hist;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance (0 = A, 1 = B); state 0/1/2 = search/measure/locked.
    int         m_state [2];
    int         m_cnt   [2];
    int         m_good  [2];
    int         m_run   [2];
    logic [3:0] m_prev  [2];
    exp_t       m_out   [2];

    exp_t q_a [$];
    exp_t q_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pw_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic logic [15:0] mask_of(input int i);
        return (i == 0) ? 16'h7FFF : 16'hFFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
            m_good[i]  = 0;
            m_run[i]   = 0;
            m_prev[i]  = 4'd0;
            m_out[i]   = '{lock: 1'b0, period: 8'd0, wraps: 8'd0, ei: 1'b0, ep: 1'b0, es: 1'b0, hist: 16'd0};
        end
    endtask

    task automatic model_step(input int i, input logic e, input logic [3:0] d, input logic clr);
        logic        hit;
        logic        sp, si, ss;
        logic [15:0] msk;
        int          cmax;
        sp   = 1'b0;
        si   = 1'b0;
        ss   = 1'b0;
        msk  = mask_of(i);
        cmax = (1 << pw_of(i)) - 1;
        if (e) begin
            hit = (d == 4'd9);
            if (m_state[i] == 0) begin
                if (hit) begin
                    m_state[i] = 1;
                    m_cnt[i]   = 1;
                end
            end else if (hit) begin
                m_out[i].period = 8'(m_cnt[i]);
                if (m_cnt[i] == 8) begin
                    if (m_state[i] == 1) begin
                        m_good[i]++;
                        if (m_good[i] >= 2) begin
                            m_state[i]    = 2;
                            m_out[i].lock = 1'b1;
                        end
                    end
                end else begin
                    sp            = 1'b1;
                    m_good[i]     = 0;
                    m_out[i].lock = 1'b0;
                    m_state[i]    = 1;
                end
                m_cnt[i] = 1;
            end else if (m_cnt[i] + 1 >= cmax) begin
                sp            = 1'b1;
                m_out[i].lock = 1'b0;
                m_good[i]     = 0;
                m_cnt[i]      = 0;
                m_state[i]    = 0;
            end else begin
                m_cnt[i]++;
            end
            if (hit && m_out[i].wraps < 8'd255) m_out[i].wraps++;
            si = ~msk[d];
            if (d != m_prev[i]) m_run[i] = 1;
            else if (m_run[i] < 4) m_run[i]++;
            ss = (m_run[i] >= 4);
            m_prev[i] = d;
            m_out[i].hist[d] = 1'b1;
        end
        if (clr) begin
            m_out[i].ei   = 1'b0;
            m_out[i].ep   = 1'b0;
            m_out[i].es   = 1'b0;
            m_out[i].hist = 16'd0;
        end else begin
            m_out[i].ei = m_out[i].ei | si;
            m_out[i].ep = m_out[i].ep | sp;
            m_out[i].es = m_out[i].es | ss;
        end
    endtask

    function automatic exp_t observe(input int i);
        exp_t o;
        o.hist = 16'd0;
        if (i == 0) begin
            o.lock = if_a.lock;  o.period = if_a.period;        o.wraps = if_a.wraps;
            o.ei = if_a.err_illegal; o.ep = if_a.err_period; o.es = if_a.err_stuck;
`ifdef SEQMON_HIST_EN
            o.hist = if_a.hist;
`endif
        end else begin
            o.lock = if_b.lock;  o.period = {4'd0, if_b.period}; o.wraps = if_b.wraps;
            o.ei = if_b.err_illegal; o.ep = if_b.err_period; o.es = if_b.err_stuck;
`ifdef SEQMON_HIST_EN
            o.hist = if_b.hist;
`endif
        end
        return o;
    endfunction

    task automatic compare(input int i);
        exp_t  ex;
        exp_t  ob;
        string p;
        p = (i == 0) ? "a" : "b";
        if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
            check({p, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            ex = (i == 0) ? q_a.pop_front() : q_b.pop_front();
            ob = observe(i);
            check({p, ".lock"},        32'(ob.lock),   32'(ex.lock));
            check({p, ".period"},      32'(ob.period), 32'(ex.period));
            check({p, ".wraps"},       32'(ob.wraps),  32'(ex.wraps));
            check({p, ".err_illegal"}, 32'(ob.ei),     32'(ex.ei));
            check({p, ".err_period"},  32'(ob.ep),     32'(ex.ep));
            check({p, ".err_stuck"},   32'(ob.es),     32'(ex.es));
`ifdef SEQMON_HIST_EN
            check({p, ".hist"},        32'(ob.hist),   32'(ex.hist));
`endif
        end
    endtask

    // One sampling edge: drive, predict, push, clock, then pop and compare.
    task automatic step(input logic e, input logic [3:0] d, input logic clr);
        if_a.e = e; if_a.d = d; if_a.clr = clr;
        if_b.e = e; if_b.d = d; if_b.clr = clr;
        model_step(0, e, d, clr);
        model_step(1, e, d, clr);
        q_a.push_back(m_out[0]);
        q_b.push_back(m_out[1]);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic others(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 4'(k), 1'b0);
    endtask

    task automatic period_seq(input int n);
        step(1'b1, 4'd9, 1'b0);
        others(n);
    endtask

    task automatic check_zero(input int i, input string tag);
        exp_t ob;
        ob = observe(i);
        check({tag, ".lock"},   32'(ob.lock),   32'd0);
        check({tag, ".period"}, 32'(ob.period), 32'd0);
        check({tag, ".wraps"},  32'(ob.wraps),  32'd0);
        check({tag, ".errs"},   32'({ob.ei, ob.ep, ob.es}), 32'd0);
        check({tag, ".hist"},   32'(ob.hist),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_a.e = 1'b0; if_a.d = 4'd0; if_a.clr = 1'b0;
        if_b.e = 1'b0; if_b.d = 4'd0; if_b.clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "a.reset");
        check_zero(1, "b.reset");
        rst = 1'b0;

        // Clean counter: lock after third start code.
        period_seq(7); period_seq(7); period_seq(7);
        check("a.locked", 32'(if_a.lock), 32'd1);
        check("a.period8", 32'(if_a.period), 32'd8);
        check("a.wraps3", 32'(if_a.wraps), 32'd3);
        check("a.no_err", 32'({if_a.err_illegal, if_a.err_period, if_a.err_stuck}), 32'd0);

        // Shortened cycle of 7 samples breaks lock; two good periods relock.
        period_seq(6);
        step(1'b1, 4'd9, 1'b0);
        check("a.short_err", 32'(if_a.err_period), 32'd1);
        check("a.short_unlock", 32'(if_a.lock), 32'd0);
        check("a.short_period", 32'(if_a.period), 32'd7);
        others(7);
        period_seq(7); period_seq(7);
        check("a.relocked", 32'(if_a.lock), 32'd1);
        check("a.wraps7", 32'(if_a.wraps), 32'd7);

        // Clear, then illegal code 15 (illegal only in A), then clear again.
        step(1'b1, 4'd0, 1'b1);
        check("a.clr_ep", 32'(if_a.err_period), 32'd0);
        step(1'b1, 4'd15, 1'b0);
        check("a.illegal", 32'(if_a.err_illegal), 32'd1);
        check("b.legal15", 32'(if_b.err_illegal), 32'd0);
        step(1'b1, 4'd1, 1'b1);
        check("a.illegal_clr", 32'(if_a.err_illegal), 32'd0);

        // Stuck: four enabled samples of 3; then held code with E=0 is harmless.
        step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd3, 1'b0);
        check("a.stuck3", 32'(if_a.err_stuck), 32'd0);
        step(1'b1, 4'd3, 1'b0);
        check("a.stuck4", 32'(if_a.err_stuck), 32'd1);
        step(1'b1, 4'd5, 1'b1);
        repeat (20) step(1'b0, 4'd5, 1'b0);
        check("a.stall_ok", 32'(if_a.err_stuck), 32'd0);

        // Start code with simultaneous clear: A's mismatch suppressed, B overflows after 15.
        step(1'b1, 4'd9, 1'b1);
        check("a.clr_wins", 32'(if_a.err_period), 32'd0);
        for (int k = 0; k < 13; k++) step(1'b1, 4'(k % 8), 1'b0);
        check("b.pre_ovf", 32'(if_b.err_period), 32'd0);
        step(1'b1, 4'd5, 1'b0);
        check("b.ovf", 32'(if_b.err_period), 32'd1);
        check("b.ovf_unlock", 32'(if_b.lock), 32'd0);
        check("a.no_ovf", 32'(if_a.err_period), 32'd0);

        // Random traffic, start code favoured.
        for (int k = 0; k < 300; k++) begin
            step(($urandom % 4) != 0,
                 (($urandom % 3) == 0) ? 4'd9 : 4'($urandom % 16),
                 ($urandom % 16) == 0);
        end

        // Relock, go mid-period, then asynchronous reset.
        step(1'b1, 4'd0, 1'b1);
        period_seq(7); period_seq(7); period_seq(7); period_seq(3);
        check("a.lock_pre_rst", 32'(if_a.lock), 32'd1);
        #2;
        rst = 1'b1;
        if_a.e = 1'b0; if_b.e = 1'b0;
        #1;
        check_zero(0, "a.arst");
        check_zero(1, "b.arst");
        model_reset();
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 4'd9, 1'b0);
        check("a.wraps_restart", 32'(if_a.wraps), 32'd1);
        others(7);
        period_seq(7); period_seq(7);
        check("a.lock_after_rst", 32'(if_a.lock), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
